// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-serial RAM/IO bus sequencer: widths,
// FSM states, size decode and the latched-request record.
package mem_arbiter_pkg;

    localparam int MemAddrBus = 32;
    localparam int MemDataBus = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    localparam logic [1:0] CNF_BYTE = 2'b00;
    localparam logic [1:0] CNF_HALF = 2'b01;

    typedef logic [MemAddrBus-1:0] mem_addr_t;
    typedef logic [MemDataBus-1:0] mem_data_t;

    typedef struct packed {
        mem_addr_t  addr;
        mem_data_t  wdata;
        logic [2:0] len;
        logic       wr;
        logic       own_inst;
    } req_t;

    // Both 2'b10 and 2'b11 mean a full word.
    function automatic logic [2:0] cnf_len(input logic [1:0] cnf);
        case (cnf)
            CNF_BYTE: cnf_len = 3'd1;
            CNF_HALF: cnf_len = 3'd2;
            default:  cnf_len = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_byte_assembler.sv
// Collects read bytes into a little-endian word, one byte lane per index.
module mem_arbiter_byte_assembler
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clear,
    input  logic       load,
    input  logic [1:0] idx,
    input  logic [7:0] din,
    output mem_data_t  word
);

    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
        end else if (en) begin
            if (clear) begin
                word <= '0;
            end else if (load) begin
                word[{idx, 3'b000} +: 8] <= din;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the 8-bit RAM/IO bus between instruction fetch and the data port,
// data first; fetches can be abandoned by a branch flush.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_busy,
    output logic              inst_done,
    output logic [DATA_W-1:0] inst_data,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [1:0]        data_cnf,
    output logic              data_busy,
    output logic              data_done,
    output logic [DATA_W-1:0] data_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    logic [1:0] state;
    req_t       req;
    logic [2:0] step;
    logic       done_q;
    logic       inst_busy_q;
    logic       data_busy_q;
    mem_data_t  inst_held;
    mem_data_t  data_held;
    mem_data_t  asm_word;
    mem_data_t  full_word;
    logic [1:0] last_idx;
    logic [2:0] step_next;
    mem_addr_t  addr_next;
    logic       grant_data;
    logic       grant_inst;
    logic       grant;
    logic       abort;
    logic       capture;

    assign grant_data = (state == ST_IDLE) && data_req;
    assign grant_inst = (state == ST_IDLE) && !data_req && inst_req && !flush;
    assign grant      = grant_data || grant_inst;
    assign abort      = (state == ST_RD) && req.own_inst && flush;
    assign step_next  = step + 3'd1;
    assign addr_next  = req.addr + mem_addr_t'(step_next);
    assign last_idx   = 2'(req.len - 3'd1);

    // mem_din trails mem_a by one cycle, so step s carries byte s-1.
    assign capture    = (state == ST_RD) && (step != 3'd0) && (step < req.len);

    // The final byte is still on mem_din during the done cycle.
    assign full_word  = asm_word | (mem_data_t'(mem_din) << {last_idx, 3'b000});

    assign inst_busy  = inst_busy_q;
    assign data_busy  = data_busy_q;
    assign inst_done  = done_q && req.own_inst && !flush;
    assign data_done  = done_q && !req.own_inst;
    assign inst_data  = inst_done ? full_word : inst_held;
    assign data_rdata = (data_done && !req.wr) ? full_word : data_held;

    mem_arbiter_byte_assembler u_asm (
        .clk   (clk),
        .rst   (rst),
        .en    (rdy),
        .clear (grant),
        .load  (capture),
        .idx   (2'(step - 3'd1)),
        .din   (mem_din),
        .word  (asm_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            req         <= '0;
            step        <= 3'd0;
            done_q      <= 1'b0;
            inst_busy_q <= 1'b0;
            data_busy_q <= 1'b0;
            inst_held   <= '0;
            data_held   <= '0;
            mem_a       <= '0;
            mem_dout    <= 8'h00;
            mem_wr      <= 1'b0;
        end else if (rdy) begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        req <= '{addr:     grant_data ? data_addr : inst_addr,
                                 wdata:    data_wdata,
                                 len:      grant_data ? cnf_len(data_cnf) : 3'd4,
                                 wr:       grant_data && data_wr,
                                 own_inst: grant_inst};
                        step  <= 3'd0;
                        mem_a <= grant_data ? data_addr : inst_addr;
                        if (grant_data && data_wr) begin
                            state       <= ST_WR;
                            mem_wr      <= 1'b1;
                            mem_dout    <= data_wdata[7:0];
                            done_q      <= (cnf_len(data_cnf) == 3'd1);
                            data_busy_q <= (cnf_len(data_cnf) != 3'd1);
                        end else begin
                            state       <= ST_RD;
                            inst_busy_q <= grant_inst;
                            data_busy_q <= grant_data;
                        end
                    end
                end
                ST_RD: begin
                    if (abort) begin
                        state       <= ST_IDLE;
                        mem_a       <= '0;
                        inst_busy_q <= 1'b0;
                        done_q      <= 1'b0;
                    end else begin
                        step <= step_next;
                        if (step_next < req.len) begin
                            mem_a <= addr_next;
                        end else if (step_next == req.len) begin
                            mem_a       <= '0;
                            done_q      <= 1'b1;
                            inst_busy_q <= 1'b0;
                            data_busy_q <= 1'b0;
                        end else begin
                            state  <= ST_IDLE;
                            done_q <= 1'b0;
                            if (req.own_inst) inst_held <= full_word;
                            else              data_held <= full_word;
                        end
                    end
                end
                ST_WR: begin
                    step <= step_next;
                    if (step_next < req.len) begin
                        mem_a    <= addr_next;
                        mem_dout <= req.wdata[{step_next[1:0], 3'b000} +: 8];
                        if (step_next == req.len - 3'd1) begin
                            done_q      <= 1'b1;
                            data_busy_q <= 1'b0;
                        end
                    end else begin
                        state    <= ST_IDLE;
                        mem_a    <= '0;
                        mem_wr   <= 1'b0;
                        mem_dout <= 8'h00;
                        done_q   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// random traffic compared every cycle against a transaction-schedule model.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        rst = 1'b1, rdy = 1'b1, flush = 1'b0;
    logic        inst_req = 1'b0, data_req = 1'b0, data_wr = 1'b0;
    logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
    logic [1:0]  data_cnf = 2'b00;
    logic        inst_busy, inst_done, data_busy, data_done, mem_wr;
    logic [31:0] inst_data, data_rdata, mem_a;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  dout;
        logic        ib, db, idn, ddn, ddn_rd, own_i, idle;
        logic [31:0] res;
    } exp_t;

    exp_t        cur;
    exp_t        sched[$];
    logic [31:0] held_i = '0, held_d = '0;
    logic [7:0]  tb_mem [logic [31:0]];
    logic [7:0]  m_mem  [logic [31:0]];
    int          vectors = 0, miscompares = 0, cycle = 0;
    bit          check_on = 1'b0, i_done_seen = 1'b0, d_done_seen = 1'b0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clock), .rst(rst), .rdy(rdy), .flush(flush),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_busy(inst_busy),
        .inst_done(inst_done), .inst_data(inst_data),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_cnf(data_cnf), .data_busy(data_busy),
        .data_done(data_done), .data_rdata(data_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    initial forever #5 clock = ~clock;

    function automatic logic [7:0] bg_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] m_read(input logic [31:0] a);
        return m_mem.exists(a) ? m_mem[a] : bg_byte(a);
    endfunction

    function automatic logic [7:0] tb_read(input logic [31:0] a);
        return tb_mem.exists(a) ? tb_mem[a] : bg_byte(a);
    endfunction

    function automatic exp_t idle_vec();
        exp_t e;
        e.a = '0; e.wr = 1'b0; e.dout = 8'h00; e.ib = 1'b0; e.db = 1'b0;
        e.idn = 1'b0; e.ddn = 1'b0; e.ddn_rd = 1'b0; e.own_i = 1'b0;
        e.idle = 1'b1; e.res = '0;
        return e;
    endfunction

    function automatic int len_of(input logic [1:0] cnf);
        return (cnf == 2'b00) ? 1 : (cnf == 2'b01) ? 2 : 4;
    endfunction

    // A read of n bytes: n address cycles, then one done cycle carrying the word.
    task automatic plan_read(input logic own_i, input logic [31:0] addr, input int n);
        exp_t        e;
        logic [31:0] res;
        res = '0;
        for (int k = 0; k < n; k++) begin
            e = idle_vec();
            e.idle = 1'b0; e.own_i = own_i; e.a = addr + 32'(k);
            e.ib = own_i; e.db = !own_i;
            res = res | (32'(m_read(addr + 32'(k))) << (8 * k));
            sched.push_back(e);
        end
        e = idle_vec();
        e.idle = 1'b0; e.own_i = own_i; e.idn = own_i;
        e.ddn = !own_i; e.ddn_rd = !own_i; e.res = res;
        sched.push_back(e);
    endtask

    // A store of n bytes: done coincides with the last write cycle.
    task automatic plan_write(input logic [31:0] addr, input logic [31:0] wd, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e = idle_vec();
            e.idle = 1'b0; e.a = addr + 32'(k); e.wr = 1'b1;
            e.dout = wd[8*k +: 8]; e.db = (k < n - 1); e.ddn = (k == n - 1);
            m_mem[addr + 32'(k)] = wd[8*k +: 8];
            sched.push_back(e);
        end
    endtask

    // Synchronous RAM that pauses together with the core.
    initial forever begin
        @(posedge clock);
        if (rdy) begin
            if (mem_wr) tb_mem[mem_a] = mem_dout;
            mem_din <= tb_read(mem_a);
        end
    end

    // Model: cur is what the outputs must be in the cycle that is starting.
    initial forever begin
        @(posedge clock);
        cycle++;
        if (rst) begin
            sched.delete();
            cur = idle_vec();
            held_i = '0;
            held_d = '0;
            check_on = 1'b1;
        end else if (rdy) begin
            if (!cur.idle && cur.own_i && flush) begin
                sched.delete();
                cur = idle_vec();
            end else begin
                if (cur.idn) held_i = cur.res;
                if (cur.ddn_rd) held_d = cur.res;
                if (!cur.idle) begin
                    if (sched.size() > 0) cur = sched.pop_front();
                    else cur = idle_vec();
                end else if (data_req) begin
                    if (data_wr) plan_write(data_addr, data_wdata, len_of(data_cnf));
                    else plan_read(1'b0, data_addr, len_of(data_cnf));
                    cur = sched.pop_front();
                end else if (inst_req && !flush) begin
                    plan_read(1'b1, inst_addr, 4);
                    cur = sched.pop_front();
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        logic        e_idn;
        logic [31:0] e_idata, e_ddata;
        @(negedge clock);
        if (check_on) begin
            e_idn   = cur.idn && !flush;
            e_idata = e_idn ? cur.res : held_i;
            e_ddata = cur.ddn_rd ? cur.res : held_d;
            vectors++;
            if (mem_a !== cur.a || mem_wr !== cur.wr || mem_dout !== cur.dout ||
                inst_busy !== cur.ib || data_busy !== cur.db || inst_done !== e_idn ||
                data_done !== cur.ddn || inst_data !== e_idata || data_rdata !== e_ddata) begin
                miscompares++;
                if (miscompares <= 20)
                    $display("[TB] FAIL cycle %0d model: got a=%h wr=%b dout=%h ib=%b db=%b idn=%b ddn=%b idata=%h ddata=%h, expected a=%h wr=%b dout=%h ib=%b db=%b idn=%b ddn=%b idata=%h ddata=%h",
                             cycle, mem_a, mem_wr, mem_dout, inst_busy, data_busy, inst_done,
                             data_done, inst_data, data_rdata, cur.a, cur.wr, cur.dout, cur.ib,
                             cur.db, e_idn, cur.ddn, e_idata, e_ddata);
            end
            i_done_seen = rdy && e_idn;
            d_done_seen = rdy && cur.ddn;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        tb_mem[a] = b;
        m_mem[a]  = b;
    endtask

    task automatic pick_data();
        logic [31:0] bases [3];
        bases[0] = 32'h0000_0100; bases[1] = 32'h0003_0000; bases[2] = 32'hFFFF_FFFC;
        data_addr  = bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 7));
        data_wdata = $urandom;
        data_cnf   = 2'($urandom_range(0, 3));
        data_wr    = $urandom_range(0, 1) == 1;
    endtask

    // One cycle of random traffic from well-behaved requesters.
    task automatic applyStimulus();
        step_cycle();
        if (rdy && !rst) begin
            if (d_done_seen) data_req = 1'b0;
            else if (!data_req && $urandom_range(0, 3) == 0) begin
                pick_data();
                data_req = 1'b1;
            end
            if (i_done_seen) inst_req = 1'b0;
            else if (flush && $urandom_range(0, 1) == 1) inst_addr = 32'h0000_0100 + 32'($urandom_range(0, 15));
            else if (!inst_req && $urandom_range(0, 2) == 0) begin
                inst_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : 32'h0000_0100 + 32'($urandom_range(0, 15));
                inst_req  = 1'b1;
            end
            flush = $urandom_range(0, 11) == 0;
        end
        rdy = $urandom_range(0, 9) != 0;
        rst = $urandom_range(0, 499) == 0;
    endtask

    initial begin
        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h00); preload(32'h103, 8'h00);
        preload(32'h200, 8'hAB);
        preload(32'h400, 8'hEF); preload(32'h401, 8'hBE);
        preload(32'h402, 8'hAD); preload(32'h403, 8'hDE);

        step_cycle();
        step_cycle();
        rst = 1'b0;
        checkOutput("reset mem_a", mem_a, 32'h0);
        checkOutput("reset busy/done/wr", {28'h0, inst_busy, data_busy, inst_done | data_done, mem_wr}, 32'h0);
        checkOutput("reset inst_data", inst_data, 32'h0);
        checkOutput("reset data_rdata", data_rdata, 32'h0);

        inst_req = 1'b1; inst_addr = 32'h100;
        step_cycle();
        checkOutput("fetch G+1 mem_a", mem_a, 32'h100);
        repeat (3) step_cycle();
        checkOutput("fetch G+4 mem_a", mem_a, 32'h103);
        step_cycle();
        checkOutput("fetch G+5 done", {31'h0, inst_done}, 32'h1);
        checkOutput("fetch inst_data", inst_data, 32'h0000_0513);
        inst_req = 1'b0;
        step_cycle();

        inst_req = 1'b1; inst_addr = 32'h100;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h200; data_cnf = 2'b00;
        step_cycle();
        checkOutput("contend G+1 busy", {30'h0, inst_busy, data_busy}, 32'h1);
        checkOutput("contend G+1 mem_a", mem_a, 32'h200);
        step_cycle();
        checkOutput("contend G+2 data_done", {31'h0, data_done}, 32'h1);
        checkOutput("contend data_rdata", data_rdata, 32'h0000_00AB);
        data_req = 1'b0;
        step_cycle();
        step_cycle();
        checkOutput("contend fetch mem_a", mem_a, 32'h100);
        checkOutput("contend inst_busy", {31'h0, inst_busy}, 32'h1);
        repeat (4) step_cycle();
        checkOutput("contend fetch done", {31'h0, inst_done}, 32'h1);
        inst_req = 1'b0;
        step_cycle();

        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h1FFFE;
        data_cnf = 2'b01; data_wdata = 32'h1234_BEEF;
        step_cycle();
        checkOutput("store G+1 bus", {mem_a[23:0], mem_dout}, {24'h01FFFE, 8'hEF});
        checkOutput("store G+1 wr", {31'h0, mem_wr}, 32'h1);
        step_cycle();
        checkOutput("store G+2 bus", {mem_a[23:0], mem_dout}, {24'h01FFFF, 8'hBE});
        checkOutput("store G+2 done/wr", {30'h0, data_done, mem_wr}, 32'h3);
        data_req = 1'b0;
        step_cycle();
        checkOutput("store G+3 wr", {31'h0, mem_wr}, 32'h0);

        inst_req = 1'b1; inst_addr = 32'h100;
        repeat (3) step_cycle();
        flush = 1'b1; inst_addr = 32'h400;
        step_cycle();
        flush = 1'b0;
        checkOutput("flush G+4 busy/done", {30'h0, inst_busy, inst_done}, 32'h0);
        checkOutput("flush G+4 mem_a", mem_a, 32'h0);
        step_cycle();
        checkOutput("refetch mem_a", mem_a, 32'h400);
        repeat (4) step_cycle();
        checkOutput("refetch done", {31'h0, inst_done}, 32'h1);
        checkOutput("refetch inst_data", inst_data, 32'hDEAD_BEEF);
        inst_req = 1'b0;
        step_cycle();

        inst_req = 1'b1; inst_addr = 32'h100;
        step_cycle();
        step_cycle();
        rdy = 1'b0;
        checkOutput("rdy low mem_a", mem_a, 32'h101);
        step_cycle();
        step_cycle();
        checkOutput("rdy low hold mem_a", mem_a, 32'h101);
        step_cycle();
        rdy = 1'b1;
        checkOutput("rdy resume mem_a", mem_a, 32'h101);
        step_cycle();
        checkOutput("rdy resume next mem_a", mem_a, 32'h102);
        repeat (2) step_cycle();
        checkOutput("rdy shifted done", {31'h0, inst_done}, 32'h1);
        checkOutput("rdy inst_data", inst_data, 32'h0000_0513);
        inst_req = 1'b0;
        step_cycle();

        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'hFFFF_FFFE; data_cnf = 2'b11;
        step_cycle(); checkOutput("wrap k0", mem_a, 32'hFFFF_FFFE);
        step_cycle(); checkOutput("wrap k1", mem_a, 32'hFFFF_FFFF);
        step_cycle(); checkOutput("wrap k2", mem_a, 32'h0000_0000);
        step_cycle(); checkOutput("wrap k3", mem_a, 32'h0000_0001);
        step_cycle();
        checkOutput("wrap done", {31'h0, data_done}, 32'h1);
        data_req = 1'b0;
        step_cycle();

        data_req = 1'b1; data_addr = 32'h0003_0000; data_cnf = 2'b00;
        step_cycle(); checkOutput("io issue", mem_a, 32'h0003_0000);
        step_cycle(); checkOutput("io single issue", mem_a, 32'h0);
        checkOutput("io done", {31'h0, data_done}, 32'h1);
        data_req = 1'b0;

        repeat (3000) applyStimulus();

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
